con_link_scheduler: RTL and testbench

// - Time-shares the single half-duplex external link (cons) between two traffic types.
// - Inbound: kernel/input load bursts requested by the conv controller.
// - Outbound: conv results produced by the output datapath.
// - Buffers results in a small FIFO, owns driving_cons and inserts bus turnaround cycles.
// - Sits between the conv controller/datapath and the top-level con_* / out_* ports.

---
 rtl/conv_link_pkg.sv | 23 ++
 rtl/con_link_scheduler_result_fifo.sv | 61 ++++++
 rtl/con_link_scheduler.sv | 130 +++++++++++++
 tb/tb_con_link_scheduler.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_link_pkg.sv
// Shared types for the cons link scheduler: FSM state encoding and the result record
// that travels through the outbound FIFO.
package conv_link_pkg;

    localparam int RES_DATA_W = 16;
    localparam int COORD_W    = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        TURN_OUT,
        DRAIN,
        TURN_IN
    } link_state_t;

    typedef struct packed {
        logic [RES_DATA_W-1:0] data;
        logic [COORD_W-1:0]    x;
        logic [COORD_W-1:0]    y;
        logic [COORD_W-1:0]    ch;
    } result_t;

endpackage

// File: rtl/con_link_scheduler_result_fifo.sv
// Synchronous result FIFO with a registered full flag; the head entry is always visible on dout.
module result_fifo
    import conv_link_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_in,
    input  logic               push,
    input  logic               pop,
    input  result_t            din,
    output result_t            dout,
    output logic               full,
    output logic               empty,
    output logic [LEVEL_W-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    result_t            mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LEVEL_W-1:0] level_next;
    logic               push_ok;
    logic               pop_ok;

    // A full FIFO refuses pushes even while popping, so full alone gates the write.
    assign push_ok = push & !full;
    assign pop_ok  = pop & !empty;
    assign empty   = (level == '0);
    assign dout    = mem[rd_ptr];

    always_comb begin
        level_next = level;
        case ({push_ok, pop_ok})
            2'b10:   level_next = level + 1'b1;
            2'b01:   level_next = level - 1'b1;
            default: level_next = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            level <= level_next;
            full  <= (level_next == LEVEL_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/con_link_scheduler.sv
// Time-shares the half-duplex cons link between inbound load bursts and outbound results,
// inserting one turnaround cycle on each direction change.
module con_link_scheduler
    import conv_link_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int HIGH_WATER  = 6,
    parameter int DRAIN_BURST = 4
) (
    input  logic                        clk,
    input  logic                        rst_in,
    input  logic                        ld_req,
    input  logic [7:0]                  ld_len,
    output logic                        ld_grant,
    output logic                        ld_done,
    output logic                        ld_word_valid,
    input  logic                        con_valid,
    output logic                        con_ready,
    input  logic                        res_valid,
    output logic                        res_ready,
    input  logic [DATA_WIDTH-1:0]       res_data,
    input  logic [31:0]                 res_x,
    input  logic [31:0]                 res_y,
    input  logic [31:0]                 res_ch,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic [31:0]                 out_x,
    output logic [31:0]                 out_y,
    output logic [31:0]                 out_ch,
    output logic                        driving_cons,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    link_state_t   state;
    logic [7:0]    remaining;
    logic [7:0]    sent;
    logic          ld_done_q;
    result_t       din;
    result_t       head;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic          push;
    logic          pop;
    logic          req_live;
    logic          at_high;
    logic          will_empty;
    logic          burst_met;

    assign din = '{data: res_data, x: res_x, y: res_y, ch: res_ch};

    result_fifo #(.DEPTH(FIFO_DEPTH), .LEVEL_W(LW)) u_fifo (
        .clk    (clk),
        .rst_in (rst_in),
        .push   (push),
        .pop    (pop),
        .din    (din),
        .dout   (head),
        .full   (full),
        .empty  (empty),
        .level  (level)
    );

    assign res_ready     = !full;
    assign push          = res_valid & !full;
    assign out_valid     = (state == DRAIN) & !empty;
    assign pop           = out_valid & out_ready;
    assign ld_grant      = (state == LOAD);
    assign con_ready     = (state == LOAD);
    assign ld_word_valid = con_valid & con_ready;
    assign driving_cons  = (state == TURN_OUT) | (state == DRAIN) | (state == TURN_IN);
    assign ld_done       = ld_done_q;
    assign fifo_level    = level;

    assign out_data = out_valid ? head.data : '0;
    assign out_x    = out_valid ? head.x    : '0;
    assign out_y    = out_valid ? head.y    : '0;
    assign out_ch   = out_valid ? head.ch   : '0;

    // The controller still holds ld_req during the ld_done cycle; it must not re-grant.
    assign req_live   = ld_req & !ld_done_q;
    assign at_high    = (level >= LW'(HIGH_WATER));
    assign will_empty = !push & (empty | ((level == LW'(1)) & pop));
    assign burst_met  = ({1'b0, sent} + 9'(pop)) >= 9'(DRAIN_BURST);

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state     <= IDLE;
            remaining <= '0;
            sent      <= '0;
            ld_done_q <= 1'b0;
        end else begin
            ld_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (at_high || (!empty && !req_live)) begin
                        state <= TURN_OUT;
                    end else if (req_live && (ld_len != 8'd0)) begin
                        state     <= LOAD;
                        remaining <= ld_len;
                    end
                end
                LOAD: begin
                    if (con_valid) begin
                        remaining <= remaining - 8'd1;
                        if (remaining == 8'd1) begin
                            state     <= IDLE;
                            ld_done_q <= 1'b1;
                        end
                    end
                end
                TURN_OUT: begin
                    sent  <= '0;
                    state <= DRAIN;
                end
                DRAIN: begin
                    if (pop && (sent != 8'hFF)) sent <= sent + 8'd1;
                    if (will_empty || (ld_req && burst_met && !at_high)) state <= TURN_IN;
                end
                TURN_IN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_con_link_scheduler.sv
// Scoreboard bench for con_link_scheduler: results queued when accepted, checked in order on pop.
module tb_con_link_scheduler;
    import conv_link_pkg::*;

    logic        clk;
    logic        rst_in;
    logic        ld_req;
    logic [7:0]  ld_len;
    logic        ld_grant;
    logic        ld_done;
    logic        ld_word_valid;
    logic        con_valid;
    logic        con_ready;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [31:0] res_x;
    logic [31:0] res_y;
    logic [31:0] res_ch;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [31:0] out_x;
    logic [31:0] out_y;
    logic [31:0] out_ch;
    logic        driving_cons;
    logic [3:0]  fifo_level;

    int      checks;
    int      failures;
    result_t sbQueue[$];

    con_link_scheduler dut (
        .clk           (clk),
        .rst_in        (rst_in),
        .ld_req        (ld_req),
        .ld_len        (ld_len),
        .ld_grant      (ld_grant),
        .ld_done       (ld_done),
        .ld_word_valid (ld_word_valid),
        .con_valid     (con_valid),
        .con_ready     (con_ready),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_x         (res_x),
        .res_y         (res_y),
        .res_ch        (res_ch),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_x         (out_x),
        .out_y         (out_y),
        .out_ch        (out_ch),
        .driving_cons  (driving_cons),
        .fifo_level    (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one result for one cycle; the scoreboard records it only if the handshake completes.
    task automatic applyStimulus(input logic valid, input logic [15:0] data, input logic [31:0] x,
                                 input logic [31:0] y, input logic [31:0] ch,
                                 output logic drvSeen, output logic ovSeen);
        result_t r;
        res_valid = valid;
        res_data  = data;
        res_x     = x;
        res_y     = y;
        res_ch    = ch;
        @(negedge clk);
        drvSeen = driving_cons;
        ovSeen  = out_valid;
        if (valid && res_ready) begin
            r = '{data: data, x: x, y: y, ch: ch};
            sbQueue.push_back(r);
        end
        step();
        res_valid = 1'b0;
    endtask

    // Enter LOAD with a one-word burst and keep it open so results pile up in the FIFO.
    task automatic holdLink();
        ld_req    = 1'b1;
        ld_len    = 8'd1;
        con_valid = 1'b0;
        step();
    endtask

    // Completes the open burst; returns at the negedge of the ld_done cycle.
    task automatic releaseLink(input logic keepReq, input logic [7:0] nextLen);
        logic found;
        found     = 1'b0;
        con_valid = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (ld_done) found = 1'b1;
            else step();
        end
        checkOutput("ld_done_seen", found, 1'b1);
        ld_req    = keepReq;
        ld_len    = nextLen;
        con_valid = 1'b0;
    endtask

    task automatic waitIdle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            @(negedge clk);
            if (fifo_level == 4'd0 && !driving_cons && !ld_grant) done = 1'b1;
        end
        checkOutput("drain_to_idle", done, 1'b1);
        step();
    endtask

    // Pops are compared in order against the scoreboard; link invariants are checked every cycle.
    always @(negedge clk) begin
        result_t expRes;
        if (out_valid && out_ready) begin
            if (sbQueue.size() == 0) begin
                checkOutput("sb_unexpected_pop", 1'b1, 1'b0);
            end else begin
                expRes = sbQueue.pop_front();
                checkOutput("sb_result", {out_data, out_x, out_y, out_ch}, expRes);
            end
        end
        checkOutput("inv_dir", con_ready & driving_cons, 1'b0);
        checkOutput("inv_ov", out_valid & !driving_cons, 1'b0);
    end

    initial begin
        int          grants;
        int          words;
        int          doneAt;
        int          pops;
        logic        sawDone;
        logic        sawGrant;
        logic        dD;
        logic        dO;
        logic [9:0]  drvLog;
        logic [9:0]  ovLog;
        logic [7:0]  grantLog;
        logic [9:0]  expDrv10;
        logic [9:0]  expOv10;
        logic [7:0]  expDrv8;
        logic [7:0]  expOv8;
        logic [7:0]  expGrant8;
        logic [15:0] heldData;

        checks    = 0;
        failures  = 0;
        rst_in    = 1'b1;
        ld_req    = 1'b0;
        ld_len    = 8'd0;
        con_valid = 1'b0;
        res_valid = 1'b0;
        res_data  = '0;
        res_x     = '0;
        res_y     = '0;
        res_ch    = '0;
        out_ready = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_grant", ld_grant, 1'b0);
        checkOutput("rst_done", ld_done, 1'b0);
        checkOutput("rst_con_ready", con_ready, 1'b0);
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_driving", driving_cons, 1'b0);
        checkOutput("rst_level", fifo_level, 4'd0);
        checkOutput("rst_res_ready", res_ready, 1'b1);
        checkOutput("rst_out_bus", {out_data, out_x, out_y, out_ch}, 112'd0);
        rst_in = 1'b0;
        step();

        // Reset in the middle of a 12-word burst
        ld_req    = 1'b1;
        ld_len    = 8'd12;
        con_valid = 1'b1;
        step();
        words = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            words += int'(ld_word_valid);
            step();
        end
        checkOutput("midload_words", words, 5);
        rst_in    = 1'b1;
        ld_req    = 1'b0;
        con_valid = 1'b0;
        step();
        rst_in   = 1'b0;
        sawDone  = 1'b0;
        sawGrant = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sawDone  |= ld_done;
            sawGrant |= ld_grant;
            step();
        end
        checkOutput("midload_no_done", sawDone, 1'b0);
        checkOutput("midload_idle", sawGrant, 1'b0);

        // Load burst with con_valid held high; ld_len changes mid-burst must be ignored
        ld_req    = 1'b1;
        ld_len    = 8'd12;
        con_valid = 1'b1;
        grants = 0; words = 0; doneAt = 0;
        for (int c = 1; c <= 30 && doneAt == 0; c++) begin
            step();
            if (c == 5) ld_len = 8'd3;
            @(negedge clk);
            grants += int'(ld_grant);
            words  += int'(ld_word_valid);
            if (ld_done) begin
                doneAt    = c;
                ld_req    = 1'b0;
                con_valid = 1'b0;
            end
        end
        step();
        checkOutput("load_grants", grants, 12);
        checkOutput("load_words", words, 12);
        checkOutput("load_done_cycle", doneAt, 13);

        // Same burst with con_valid toggling every cycle
        ld_req    = 1'b1;
        ld_len    = 8'd12;
        con_valid = 1'b0;
        grants = 0; words = 0; doneAt = 0;
        for (int c = 1; c <= 40 && doneAt == 0; c++) begin
            step();
            con_valid = c[0];
            @(negedge clk);
            grants += int'(ld_grant);
            words  += int'(ld_word_valid);
            if (ld_done) begin
                doneAt    = c;
                ld_req    = 1'b0;
                con_valid = 1'b0;
            end
        end
        step();
        checkOutput("toggle_grants", grants, 23);
        checkOutput("toggle_words", words, 12);
        checkOutput("toggle_done_cycle", doneAt, 24);

        // Drain only: three results, turnaround on each side
        out_ready = 1'b1;
        expDrv10  = 10'b00_0111_1100;
        expOv10   = 10'b00_0011_1000;
        for (int c = 0; c < 10; c++) begin
            if (c == 0)      applyStimulus(1'b1, 16'h11, 32'd0, 32'd0, 32'd0, dD, dO);
            else if (c == 1) applyStimulus(1'b1, 16'h22, 32'd1, 32'd0, 32'd0, dD, dO);
            else if (c == 2) applyStimulus(1'b1, 16'h33, 32'd2, 32'd0, 32'd0, dD, dO);
            else             applyStimulus(1'b0, 16'h00, 32'd0, 32'd0, 32'd0, dD, dO);
            drvLog[c] = dD;
            ovLog[c]  = dO;
        end
        for (int c = 0; c < 10; c++) begin
            checkOutput($sformatf("drain_drv_c%0d", c), drvLog[c], expDrv10[c]);
            checkOutput($sformatf("drain_ov_c%0d", c), ovLog[c], expOv10[c]);
        end

        // Back-pressure with a full FIFO
        holdLink();
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b1, 16'h100 + 16'(i), 32'(i), 32'(i + 10), 32'(i + 20), dD, dO);
        @(negedge clk);
        checkOutput("bp_full_level", fifo_level, 4'd8);
        checkOutput("bp_full_ready", res_ready, 1'b0);
        out_ready = 1'b0;
        step();
        releaseLink(1'b0, 8'd0);
        step();
        step();
        res_valid = 1'b1;
        res_data  = 16'hDEAD;
        heldData  = 16'h100;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0 || i == 9) begin
                checkOutput($sformatf("bp_ov_%0d", i), out_valid, 1'b1);
                checkOutput($sformatf("bp_data_%0d", i), out_data, heldData);
                checkOutput($sformatf("bp_level_%0d", i), fifo_level, 4'd8);
                checkOutput($sformatf("bp_res_ready_%0d", i), res_ready, 1'b0);
            end
            step();
        end
        out_ready = 1'b1;
        pops = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) checkOutput("bp_full_pop_no_push", res_ready, 1'b0);
            pops += int'(out_valid & out_ready);
            step();
            res_valid = 1'b0;
        end
        checkOutput("bp_pops", pops, 8);
        waitIdle();

        // Contention: level 7 with ld_req pending drains first, then yields after DRAIN_BURST pops
        holdLink();
        for (int i = 0; i < 7; i++)
            applyStimulus(1'b1, 16'h200 + 16'(i), 32'(i), 32'd7, 32'd3, dD, dO);
        releaseLink(1'b1, 8'd2);
        out_ready = 1'b1;
        expDrv8   = 8'b0011_1111;
        expOv8    = 8'b0001_1110;
        expGrant8 = 8'b1000_0000;
        for (int k = 0; k < 8; k++) begin
            step();
            @(negedge clk);
            drvLog[k]   = driving_cons;
            ovLog[k]    = out_valid;
            grantLog[k] = ld_grant;
            if (k == 5) checkOutput("cont_level_turnin", fifo_level, 4'd3);
        end
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("cont_drv_%0d", k), drvLog[k], expDrv8[k]);
            checkOutput($sformatf("cont_ov_%0d", k), ovLog[k], expOv8[k]);
            checkOutput($sformatf("cont_grant_%0d", k), grantLog[k], expGrant8[k]);
        end
        step();
        releaseLink(1'b0, 8'd0);
        waitIdle();

        // Simultaneous push and pop in DRAIN at level 4
        out_ready = 1'b0;
        holdLink();
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 16'h60 + 16'(i), 32'(i), 32'd1, 32'd2, dD, dO);
        releaseLink(1'b0, 8'd0);
        step();
        step();
        out_ready = 1'b1;
        applyStimulus(1'b1, 16'h77, 32'd9, 32'd8, 32'd7, dD, dO);
        out_ready = 1'b0;
        checkOutput("pp_popped_in_drain", dO, 1'b1);
        @(negedge clk);
        checkOutput("pp_level", fifo_level, 4'd4);
        checkOutput("pp_still_drain", out_valid, 1'b1);
        step();
        out_ready = 1'b1;
        waitIdle();

        checkOutput("sb_left", sbQueue.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
